// File: rtl/spike_event_recorder_if.sv
// Handshake bundle between the SNN step producer / readout side and spike_event_recorder.
// SPIKE_EVT_DROP_CNT_EN adds the drop_count readout.
interface spike_event_recorder_if #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TS_WIDTH = 6,
  parameter int unsigned N_OUT    = 2
);
  logic                          step_valid;
  logic [N_OUT-1:0]              output_spikes;
  logic                          rd_en;
  logic [TS_WIDTH+N_OUT-1:0]     event_data;
  logic                          event_valid;
  logic [$clog2(DEPTH+1)-1:0]    event_count;
  logic                          full;
  logic                          overflow;
`ifdef SPIKE_EVT_DROP_CNT_EN
  logic [7:0]                    drop_count;
`endif

  modport master (
    output step_valid, output_spikes, rd_en,
`ifdef SPIKE_EVT_DROP_CNT_EN
    input  drop_count,
`endif
    input  event_data, event_valid, event_count, full, overflow
  );

  modport slave (
    input  step_valid, output_spikes, rd_en,
`ifdef SPIKE_EVT_DROP_CNT_EN
    output drop_count,
`endif
    output event_data, event_valid, event_count, full, overflow
  );
endinterface

// File: rtl/spike_event_recorder.sv
// Records non-zero SNN output spike vectors, tagged with a step timestamp, into a show-ahead FIFO.
// Optional SPIKE_EVT_DROP_CNT_EN adds a saturating dropped-event counter.
module spike_event_recorder #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TS_WIDTH = 6,
  parameter int unsigned N_OUT    = 2
) (
  input  logic                  system_clock,
  input  logic                  reset,
  input  logic                  clear,
  spike_event_recorder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned EW = TS_WIDTH + N_OUT;

  logic [EW-1:0]       mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count, count_next;
  logic [TS_WIDTH-1:0] ts;
  logic                valid_q, full_q, ovf_q;
  logic                push_req, push, pop, drop;

  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  always_comb begin
    push_req   = bus.step_valid & (|bus.output_spikes);
    pop        = bus.rd_en & valid_q;
    push       = push_req & (~full_q | pop);
    drop       = push_req & full_q & ~pop;
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!clear && push) begin
      mem[wr_ptr] <= {ts, bus.output_spikes};
    end
  end

  // valid/full are registered from the same next-count value as event_count.
  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ts      <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ts      <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (bus.step_valid) ts <= ts + TS_WIDTH'(1);
      if (drop) ovf_q <= 1'b1;
      count   <= count_next;
      valid_q <= (count_next != '0);
      full_q  <= (count_next == CW'(DEPTH));
    end
  end

`ifdef SPIKE_EVT_DROP_CNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (clear) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign bus.drop_count = drop_cnt;
`endif

  assign bus.event_data  = mem[rd_ptr];
  assign bus.event_valid = valid_q;
  assign bus.event_count = count;
  assign bus.full        = full_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_spike_event_recorder.sv
// Scoreboard bench for spike_event_recorder: a queue model of the FIFO holds expected events.
module tb_spike_event_recorder;
  logic clk;
  logic rst_n;
  logic clr;

  spike_event_recorder_if #(.DEPTH(16), .TS_WIDTH(6), .N_OUT(2)) bus ();

  spike_event_recorder #(.DEPTH(16), .TS_WIDTH(6), .N_OUT(2)) dut (
    .system_clock (clk),
    .reset        (rst_n),
    .clear        (clr),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total;
  int         bad;
  logic [7:0] q[$];
  logic [5:0] m_ts;
  logic       m_ovf;
  int         m_drop;

  task automatic model_reset();
    q.delete();
    m_ts   = '0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic idle_inputs();
    bus.step_valid    = 1'b0;
    bus.output_spikes = 2'b00;
    bus.rd_en         = 1'b0;
    clr               = 1'b0;
  endtask

  // Drive one clock of stimulus (called at a negedge) and advance the model.
  task automatic cycle(input logic sv, input logic [1:0] sp, input logic rd, input logic c);
    bit pop;
    bus.step_valid    = sv;
    bus.output_spikes = sp;
    bus.rd_en         = rd;
    clr               = c;
    if (c) begin
      model_reset();
    end else begin
      pop = rd && (q.size() != 0);
      if (pop) void'(q.pop_front());
      if (sv && sp != 2'b00) begin
        if (q.size() < 16) q.push_back({m_ts, sp});
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (sv) m_ts = m_ts + 6'd1;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.event_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.event_count); end
    total++; if (bus.event_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.event_valid); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
    total++; if (bus.event_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus.event_data); end
    // asynchronous reset in the middle of a clock phase
    cycle(1'b1, 2'b11, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.event_count !== 5'd0) begin bad++; $display("FAIL async_reset_count got=%0d exp=0", bus.event_count); end
    total++; if (bus.event_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid got=%b exp=0", bus.event_valid); end
    total++; if (bus.event_data !== 8'h00) begin bad++; $display("FAIL async_reset_data got=%h exp=00", bus.event_data); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_event();
    do_reset();
    cycle(1'b1, 2'b01, 1'b0, 1'b0);
    total++; if (bus.event_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", bus.event_valid); end
    total++; if (bus.event_data !== 8'h01) begin bad++; $display("FAIL first_data got=%h exp=01", bus.event_data); end
    total++; if (bus.event_count !== 5'd1) begin bad++; $display("FAIL first_count got=%0d exp=1", bus.event_count); end
    total++; if (bus.event_data !== q[0]) begin bad++; $display("FAIL first_pop got=%h exp=%h", bus.event_data, q[0]); end
    cycle(1'b0, 2'b00, 1'b1, 1'b0);
    total++; if (bus.event_valid !== 1'b0) begin bad++; $display("FAIL first_drained got=%b exp=0", bus.event_valid); end
  endtask

  task automatic test_zero_skip();
    do_reset();
    cycle(1'b1, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, 1'b0, 1'b0);
    total++; if (bus.event_data !== 8'h0A) begin bad++; $display("FAIL skip_data got=%h exp=0a", bus.event_data); end
    total++; if (bus.event_count !== 5'd1) begin bad++; $display("FAIL skip_count got=%0d exp=1", bus.event_count); end
    cycle(1'b1, 2'b01, 1'b0, 1'b0);
    while (q.size() != 0) begin
      total++; if (bus.event_data !== q[0]) begin bad++; $display("FAIL skip_pop got=%h exp=%h", bus.event_data, q[0]); end
      cycle(1'b0, 2'b00, 1'b1, 1'b0);
    end
    total++; if (m_ts !== 6'd4) begin bad++; $display("FAIL skip_model_ts got=%0d exp=4", m_ts); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 64; i++) cycle(1'b1, 2'b00, 1'b0, 1'b0);
    total++; if (bus.event_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%b exp=0", bus.event_valid); end
    cycle(1'b1, 2'b11, 1'b0, 1'b0);
    total++; if (bus.event_data !== 8'h03) begin bad++; $display("FAIL wrap_data got=%h exp=03", bus.event_data); end
    cycle(1'b1, 2'b10, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, 1'b1, 1'b0);
    total++; if (bus.event_data !== 8'h06) begin bad++; $display("FAIL wrap_next got=%h exp=06", bus.event_data); end
  endtask

  task automatic test_overflow();
    logic [1:0] sp;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      sp = 2'($urandom_range(1, 3));
      if (i == 0) sp = 2'b01;
      cycle(1'b1, sp, 1'b0, 1'b0);
    end
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", bus.full); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
    total++; if (bus.event_count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", bus.event_count); end
    total++; if (bus.event_data !== 8'h01) begin bad++; $display("FAIL ovf_head got=%h exp=01", bus.event_data); end
`ifdef SPIKE_EVT_DROP_CNT_EN
    total++; if (bus.drop_count !== 8'(m_drop)) begin bad++; $display("FAIL ovf_drop_count got=%0d exp=%0d", bus.drop_count, m_drop); end
`endif
    while (q.size() != 0) begin
      total++; if (bus.event_data !== q[0]) begin bad++; $display("FAIL ovf_drain got=%h exp=%h", bus.event_data, q[0]); end
      cycle(1'b0, 2'b00, 1'b1, 1'b0);
    end
    total++; if (bus.event_count !== 5'd0) begin bad++; $display("FAIL ovf_drain_count got=%0d exp=0", bus.event_count); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 2'b10, 1'b0, 1'b0);
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL fpp_full got=%b exp=1", bus.full); end
    total++; if (bus.event_data !== q[0]) begin bad++; $display("FAIL fpp_head got=%h exp=%h", bus.event_data, q[0]); end
    cycle(1'b1, 2'b01, 1'b1, 1'b0);
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%b exp=0", bus.overflow); end
    total++; if (bus.event_count !== 5'd16) begin bad++; $display("FAIL fpp_count got=%0d exp=16", bus.event_count); end
    total++; if (bus.event_data !== 8'h06) begin bad++; $display("FAIL fpp_head_adv got=%h exp=06", bus.event_data); end
    while (q.size() != 0) begin
      total++; if (bus.event_data !== q[0]) begin bad++; $display("FAIL fpp_drain got=%h exp=%h", bus.event_data, q[0]); end
      cycle(1'b0, 2'b00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_empty_read_clear();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 1'b1, 1'b0);
    total++; if (bus.event_count !== 5'd0) begin bad++; $display("FAIL empty_rd_count got=%0d exp=0", bus.event_count); end
    cycle(1'b1, 2'b10, 1'b1, 1'b0);
    total++; if (bus.event_count !== 5'd1) begin bad++; $display("FAIL empty_pushpop_count got=%0d exp=1", bus.event_count); end
    total++; if (bus.event_data !== 8'h02) begin bad++; $display("FAIL empty_pushpop_data got=%h exp=02", bus.event_data); end
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'b11, 1'b0, 1'b0);
    total++; if (bus.event_count !== 5'd5) begin bad++; $display("FAIL pre_clear_count got=%0d exp=5", bus.event_count); end
    cycle(1'b1, 2'b11, 1'b1, 1'b1);
    total++; if (bus.event_count !== 5'd0) begin bad++; $display("FAIL clear_count got=%0d exp=0", bus.event_count); end
    total++; if (bus.event_valid !== 1'b0) begin bad++; $display("FAIL clear_valid got=%b exp=0", bus.event_valid); end
    for (int i = 0; i < 17; i++) cycle(1'b1, 2'b01, 1'b0, 1'b0);
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL pre_clear_ovf got=%b exp=1", bus.overflow); end
    cycle(1'b0, 2'b00, 1'b0, 1'b1);
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL clear_ovf got=%b exp=0", bus.overflow); end
`ifdef SPIKE_EVT_DROP_CNT_EN
    total++; if (bus.drop_count !== 8'd0) begin bad++; $display("FAIL clear_drop_count got=%0d exp=0", bus.drop_count); end
`endif
    cycle(1'b1, 2'b01, 1'b0, 1'b0);
    total++; if (bus.event_data !== 8'h01) begin bad++; $display("FAIL clear_ts got=%h exp=01", bus.event_data); end
  endtask

  task automatic test_back_to_back();
    logic       sv, rd, c;
    logic [1:0] sp;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      total++; if (bus.event_count !== 5'(q.size())) begin bad++; $display("FAIL b2b_count cyc=%0d got=%0d exp=%0d", i, bus.event_count, q.size()); end
      total++; if (bus.full !== (q.size() == 16)) begin bad++; $display("FAIL b2b_full cyc=%0d got=%b", i, bus.full); end
      total++; if (bus.overflow !== m_ovf) begin bad++; $display("FAIL b2b_ovf cyc=%0d got=%b exp=%b", i, bus.overflow, m_ovf); end
`ifdef SPIKE_EVT_DROP_CNT_EN
      total++; if (bus.drop_count !== 8'(m_drop)) begin bad++; $display("FAIL b2b_drop cyc=%0d got=%0d exp=%0d", i, bus.drop_count, m_drop); end
`endif
      if (q.size() != 0) begin
        total++; if (bus.event_data !== q[0]) begin bad++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", i, bus.event_data, q[0]); end
      end
      sv = ($urandom_range(0, 3) != 0);
      sp = 2'($urandom_range(0, 3));
      rd = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 99) == 0);
      cycle(sv, sp, rd, c);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_first_event();
    test_zero_skip();
    test_wrap();
    test_overflow();
    test_full_push_pop();
    test_empty_read_clear();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
